fifo_stream_reader: RTL and testbench

- Read-side companion to the team's synchronous FIFO.
- Drains the FIFO through its rd_en/data_out/empty interface and presents the words as a valid/ready stream.
- Absorbs the FIFO's 1-cycle registered read latency with a 2-entry skid buffer, so it sustains 1 word/cycle under back-pressure.
- Marks packet boundaries with a last flag every PKT_LEN words.

---
 rtl/fifo_stream_reader.sv | 80 ++++++++
 tb/tb_fifo_stream_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (rd_en/data_out/empty) into a valid/ready stream through a
// 2-entry skid buffer, tagging every PKT_LEN-th word with m_last.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  infl_q, infl_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic       pop;
  logic [2:0] level;

  assign pop   = (occ_q != 2'd0) & m_ready;
  // Words committed to the buffer once this cycle's pop retires; keeping it
  // below 2 before issuing means a capture always finds a free slot.
  assign level = 3'(occ_q) + 3'(infl_q) - 3'(pop);

  assign fifo_rd_en = !rst & !fifo_empty & (level < 3'd2);

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid & (cnt_q == CNT_MAX);
  assign busy    = m_valid | infl_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    infl_d = fifo_rd_en;

    if (pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end

    // The read issued last cycle lands now, behind whatever survives the pop.
    if (infl_q) begin
      if (occ_d == 2'd0) head_d = fifo_data;
      else               tail_d = fifo_data;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO feeding the DUT, scoreboard of written
// words, and a monitor comparing the stream against FIFO order and packet position.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int PL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  logic          f1_empty;
  logic [DW-1:0] f1_data;
  logic          f1_rd_en;
  logic          v1;
  logic          r1 = 1'b1;
  logic [DW-1:0] d1;
  logic          l1;
  logic          b1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:1023];
  int            wptr = 0;
  int            rptr = 0;
  int            rd_cnt = 0;
  int            pop_cnt = 0;
  int            cyc = 0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          gap_en = 1'b0;

  int            rem1 = 0;
  logic [DW-1:0] nxt1 = '0;
  int            exp1 = 0;

  logic [DW-1:0] wq[$];
  logic [DW-1:0] sb[$];

  int            pop_idx = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic          lat_arm = 1'b0;
  int            t_fall = -1;

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(f1_empty), .fifo_data(f1_data),
    .fifo_rd_en(f1_rd_en), .m_valid(v1), .m_ready(r1),
    .m_data(d1), .m_last(l1), .busy(b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural synchronous FIFO: registered read data, empty derived from pointers.
  assign fifo_empty = (wptr == rptr);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      wptr <= 0; rptr <= 0; rd_cnt <= 0; pop_cnt <= 0;
    end else begin
      if (wr_en) begin
        mem[wptr % 1024] <= wr_data;
        wptr <= wptr + 1;
      end
      if (fifo_rd_en && !fifo_empty) begin
        fifo_data <= mem[rptr % 1024];
        rptr      <= rptr + 1;
        rd_cnt    <= rd_cnt + 1;
      end
      if (m_valid && m_ready) pop_cnt <= pop_cnt + 1;
    end
  end

  // Source for the PKT_LEN=1 instance: 8 incrementing words after every reset.
  assign f1_empty = (rem1 == 0);
  always @(posedge clk) begin
    if (rst) begin
      rem1 <= 8; nxt1 <= 8'h40;
    end else if (f1_rd_en && !f1_empty) begin
      f1_data <= nxt1; nxt1 <= nxt1 + 8'd1; rem1 <= rem1 - 1;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (wq.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        wr_data = wq.pop_front();
        wr_en   = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      chk("rd_en_in_rst", 32'(fifo_rd_en), 32'd0);
      chk("rd_en1_in_rst", 32'(f1_rd_en), 32'd0);
      pop_idx    = 0;
      prev_stall = 1'b0;
      exp1       = 0;
    end else begin
      if (fifo_empty) chk("rd_en_when_empty", 32'(fifo_rd_en), 32'd0);
      chk("outstanding_le2", 32'((rd_cnt - pop_cnt) <= 2), 32'd1);
      chk("busy", 32'(busy), 32'(rd_cnt != pop_cnt));
      if (!m_valid) chk("last_idle", 32'(m_last), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h, expected no word", m_data);
        end else begin
          e = sb.pop_front();
          chk("data", 32'(m_data), 32'(e));
          chk("last", 32'(m_last), 32'((pop_idx % PL) == PL - 1));
          pop_idx++;
        end
      end
      if (lat_arm) begin
        if (t_fall < 0 && !fifo_empty) t_fall = cyc;
        if (t_fall >= 0 && m_valid) begin
          chk("first_latency", 32'(cyc - t_fall), 32'd2);
          lat_arm = 1'b0;
        end
      end
      if (v1) begin
        chk("pkt1_last", 32'(l1), 32'd1);
        chk("pkt1_data", 32'(d1), 32'(8'h40 + 8'(exp1)));
        exp1++;
      end else begin
        chk("pkt1_last_idle", 32'(l1), 32'd0);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic push(input logic [DW-1:0] d);
    wq.push_back(d);
    sb.push_back(d);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(wq.size() == 0 && sb.size() == 0 && !busy && fifo_empty && !wr_en)) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        checks++; errors++;
        $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        return;
      end
    end
    checks++;
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic drain with first-word latency measurement.
    @(posedge clk); #1;
    m_ready = 1'b1; t_fall = -1; lat_arm = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    wait_idle("basic_drain", 50);
    chk("latency_seen", 32'(lat_arm), 32'd0);

    // Back-pressure: buffer fills to two words, reads stop, head holds.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    repeat (12) @(posedge clk);
    #1;
    chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'h00);
    chk("bp_level", 32'(rd_cnt - pop_cnt), 32'd2);
    m_ready = 1'b1;
    wait_idle("backpressure", 50);

    // Single word then empty: no extra read, stream goes quiet.
    push(8'h5A);
    wait_idle("single_word", 30);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_valid", 32'(m_valid), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("reads_eq_writes", 32'(rd_cnt), 32'(wptr));

    // Random data, write gaps and random m_ready.
    gap_en = 1'b1;
    for (int i = 0; i < 256; i++) push(8'($urandom));
    for (int n = 0; n < 3000 && (sb.size() != 0 || wq.size() != 0); n++) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    wait_idle("random", 100);
    gap_en = 1'b0;
    push(8'hC3);
    wait_idle("offset_word", 30);

    // Reset with a full buffer; packet position must restart.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    for (int n = 0; n < 40 && wq.size() != 0; n++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_level", 32'(rd_cnt - pop_cnt), 32'd2);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete(); sb.delete();
    @(negedge clk);
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_last", 32'(m_last), 32'd0);
    chk("post_rst_data", 32'(m_data), 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    wait_idle("after_reset", 40);
    repeat (5) @(posedge clk);
    #1;
    chk("pkt1_word_count", 32'(exp1), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
